// File: rtl/mul_issue.sv
// mul_issue: front stage of the iterative RV32M multiplier.
// Converts the operands to unsigned magnitudes and accumulates eight of the
// nine 11x11 slice products through a single shared multiplier. It then
// issues the partial sum, the A1/B0 mid slices and the sign to the mid stage.
// Optional feature macro: MUL_ZERO_SKIP_EN. When it is defined, a zero
// magnitude operand bypasses accumulation and issues on the next cycle.
module mul_issue #(
  parameter int unsigned TAG_W = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic [1:0]       REQ_OP,
  input  logic [31:0]      REQ_RS1,
  input  logic [31:0]      REQ_RS2,
  input  logic [TAG_W-1:0] REQ_TAG,
  input  logic             FLUSH,
  input  logic             DN_READY,
  output logic             EN,
  output logic             RDY_M,
  output logic             SIGN,
  output logic [10:0]      RS1_U_MID,
  output logic [10:0]      RS2_U_MID,
  output logic [63:0]      SUM,
  output logic [1:0]       OP_OUT,
  output logic [TAG_W-1:0] TAG_OUT
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned SL_W  = 11;
  localparam int unsigned PR_W  = 2 * SL_W;
  localparam int unsigned ACC_W = 64;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned SH_W  = 6;

  localparam logic [1:0]       OP_MUL    = 2'b00;
  localparam logic [1:0]       OP_MULH   = 2'b01;
  localparam logic [1:0]       OP_MULHU  = 2'b11;
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(7);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_ISSUE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [XLEN-1:0]  a_q, a_d;
  logic [XLEN-1:0]  b_q, b_d;
  logic             ready_q, ready_d;
  logic             en_q, en_d;
  logic             sign_q, sign_d;
  logic [SL_W-1:0]  rs1_mid_q, rs1_mid_d;
  logic [SL_W-1:0]  rs2_mid_q, rs2_mid_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [1:0]       op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic             s1_c, s2_c, neg1_c, neg2_c;
  logic [XLEN-1:0]  a_mag_c, b_mag_c;
  logic             accept_c;
  logic             zero_skip_c;
  logic [1:0]       sel_i_c, sel_j_c;
  logic [SH_W-1:0]  shift_c;
  logic [SL_W-1:0]  sl_a_c, sl_b_c;
  logic [PR_W-1:0]  prod_c;
  logic [ACC_W-1:0] term_c;

  // Slice idx of a 32-bit magnitude; slice 2 is zero-extended to 11 bits.
  function automatic logic [SL_W-1:0] slice(input logic [XLEN-1:0] v, input logic [1:0] idx);
    logic [SL_W-1:0] r;
    case (idx)
      2'd0:    r = v[10:0];
      2'd1:    r = v[21:11];
      default: r = {1'b0, v[31:22]};
    endcase
    return r;
  endfunction

  // Operand signedness, magnitudes and the accept condition.
  always_comb begin
    s1_c     = (REQ_OP != OP_MULHU);
    s2_c     = (REQ_OP == OP_MUL) || (REQ_OP == OP_MULH);
    neg1_c   = s1_c & REQ_RS1[31];
    neg2_c   = s2_c & REQ_RS2[31];
    a_mag_c  = neg1_c ? (~REQ_RS1 + XLEN'(1)) : REQ_RS1;
    b_mag_c  = neg2_c ? (~REQ_RS2 + XLEN'(1)) : REQ_RS2;
    accept_c = (state_q == ST_IDLE) && REQ_VALID && !FLUSH;
`ifdef MUL_ZERO_SKIP_EN
    zero_skip_c = (a_mag_c == '0) || (b_mag_c == '0);
`else
    zero_skip_c = 1'b0;
`endif
  end

  // Pair schedule for the shared 11x11 multiplier; pair (1,0) is left to the mid stage.
  always_comb begin
    sel_i_c = 2'd0;
    sel_j_c = 2'd0;
    shift_c = SH_W'(0);
    case (cnt_q)
      3'd0: begin sel_i_c = 2'd0; sel_j_c = 2'd0; shift_c = SH_W'(0);  end
      3'd1: begin sel_i_c = 2'd0; sel_j_c = 2'd1; shift_c = SH_W'(11); end
      3'd2: begin sel_i_c = 2'd0; sel_j_c = 2'd2; shift_c = SH_W'(22); end
      3'd3: begin sel_i_c = 2'd1; sel_j_c = 2'd1; shift_c = SH_W'(22); end
      3'd4: begin sel_i_c = 2'd1; sel_j_c = 2'd2; shift_c = SH_W'(33); end
      3'd5: begin sel_i_c = 2'd2; sel_j_c = 2'd0; shift_c = SH_W'(22); end
      3'd6: begin sel_i_c = 2'd2; sel_j_c = 2'd1; shift_c = SH_W'(33); end
      default: begin sel_i_c = 2'd2; sel_j_c = 2'd2; shift_c = SH_W'(44); end
    endcase
    sl_a_c = slice(a_q, sel_i_c);
    sl_b_c = slice(b_q, sel_j_c);
    prod_c = PR_W'(sl_a_c) * PR_W'(sl_b_c);
    term_c = ACC_W'(prod_c) << shift_c;
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; FLUSH overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept_c) state_d = zero_skip_c ? ST_ISSUE : ST_ACC;
      ST_ACC:   if (cnt_q == LAST_CNT) state_d = ST_ISSUE;
      ST_ISSUE: if (DN_READY) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (FLUSH) state_d = ST_IDLE;
  end

  // Output and datapath next values.
  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    a_d       = a_q;
    b_d       = b_q;
    sign_d    = sign_q;
    rs1_mid_d = rs1_mid_q;
    rs2_mid_d = rs2_mid_q;
    sum_d     = sum_q;
    op_d      = op_q;
    tag_d     = tag_q;
    ready_d   = (state_d == ST_IDLE);
    en_d      = (state_d == ST_ISSUE);

    if (accept_c) begin
      a_d       = a_mag_c;
      b_d       = b_mag_c;
      sign_d    = (neg1_c ^ neg2_c) & !zero_skip_c;
      op_d      = REQ_OP;
      tag_d     = REQ_TAG;
      acc_d     = '0;
      cnt_d     = '0;
      rs1_mid_d = a_mag_c[21:11];
      rs2_mid_d = b_mag_c[10:0];
      if (zero_skip_c) sum_d = '0;
    end else if (FLUSH) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (state_q == ST_ACC) begin
      acc_d = acc_q + term_c;
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == LAST_CNT) sum_d = acc_q + term_c;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      ready_q   <= 1'b1;
      en_q      <= 1'b0;
      sign_q    <= 1'b0;
      rs1_mid_q <= '0;
      rs2_mid_q <= '0;
      sum_q     <= '0;
      op_q      <= '0;
      tag_q     <= '0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      a_q       <= a_d;
      b_q       <= b_d;
      ready_q   <= ready_d;
      en_q      <= en_d;
      sign_q    <= sign_d;
      rs1_mid_q <= rs1_mid_d;
      rs2_mid_q <= rs2_mid_d;
      sum_q     <= sum_d;
      op_q      <= op_d;
      tag_q     <= tag_d;
    end
  end

  assign REQ_READY = ready_q;
  assign EN        = en_q;
  assign RDY_M     = en_q;
  assign SIGN      = sign_q;
  assign RS1_U_MID = rs1_mid_q;
  assign RS2_U_MID = rs2_mid_q;
  assign SUM       = sum_q;
  assign OP_OUT    = op_q;
  assign TAG_OUT   = tag_q;

endmodule

// File: tb/tb_mul_issue.sv
// Self-checking bench for mul_issue against a full-product arithmetic model.
module tb_mul_issue;

  localparam int unsigned TAG_W = 5;

  logic             CLK;
  logic             RST;
  logic             REQ_VALID;
  logic             REQ_READY;
  logic [1:0]       REQ_OP;
  logic [31:0]      REQ_RS1;
  logic [31:0]      REQ_RS2;
  logic [TAG_W-1:0] REQ_TAG;
  logic             FLUSH;
  logic             DN_READY;
  logic             EN;
  logic             RDY_M;
  logic             SIGN;
  logic [10:0]      RS1_U_MID;
  logic [10:0]      RS2_U_MID;
  logic [63:0]      SUM;
  logic [1:0]       OP_OUT;
  logic [TAG_W-1:0] TAG_OUT;

  int n_checks = 0;
  int n_errors = 0;

  mul_issue #(.TAG_W(TAG_W)) dut (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_OP(REQ_OP), .REQ_RS1(REQ_RS1), .REQ_RS2(REQ_RS2), .REQ_TAG(REQ_TAG),
    .FLUSH(FLUSH), .DN_READY(DN_READY), .EN(EN), .RDY_M(RDY_M), .SIGN(SIGN),
    .RS1_U_MID(RS1_U_MID), .RS2_U_MID(RS2_U_MID), .SUM(SUM),
    .OP_OUT(OP_OUT), .TAG_OUT(TAG_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference: full 64-bit product of magnitudes minus the mid-stage slice term.
  task automatic model(input logic [1:0] op, input logic [31:0] r1, input logic [31:0] r2,
                       output logic [63:0] sum, output logic [10:0] m1, output logic [10:0] m2,
                       output logic sg, output int lat);
    logic s1, s2, n1, n2;
    logic [31:0] a, b;
    s1  = (op != 2'b11);
    s2  = (op == 2'b00) || (op == 2'b01);
    n1  = s1 && r1[31];
    n2  = s2 && r2[31];
    a   = n1 ? 32'(0 - r1) : r1;
    b   = n2 ? 32'(0 - r2) : r2;
    m1  = a[21:11];
    m2  = b[10:0];
    sum = (64'(a) * 64'(b)) - ((64'(m1) * 64'(m2)) << 11);
    sg  = n1 ^ n2;
    lat = 9;
`ifdef MUL_ZERO_SKIP_EN
    if (a == 0 || b == 0) begin
      sg  = 1'b0;
      lat = 1;
    end
`endif
  endtask

  task automatic run_req(input logic [1:0] op, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [TAG_W-1:0] tg, input int stall, input bit kill);
    logic [63:0] e_sum;
    logic [10:0] e_m1, e_m2;
    logic        e_sg;
    int          e_lat;
    int          lat;
    model(op, r1, r2, e_sum, e_m1, e_m2, e_sg, e_lat);
    check_eq("ready_idle", 64'(REQ_READY), 64'd1);
    REQ_VALID = 1'b1; REQ_OP = op; REQ_RS1 = r1; REQ_RS2 = r2; REQ_TAG = tg;
    tick();
    REQ_VALID = 1'b0; REQ_RS1 = $urandom; REQ_RS2 = $urandom; REQ_OP = 2'($urandom);
    lat = 1;
    while (!EN && lat < 40) begin
      tick();
      lat++;
    end
    check_eq("latency", 64'(lat), 64'(e_lat));
    check_eq("en", 64'(EN), 64'd1);
    check_eq("rdy_m", 64'(RDY_M), 64'd1);
    check_eq("sum", SUM, e_sum);
    check_eq("sign", 64'(SIGN), 64'(e_sg));
    check_eq("rs1_mid", 64'(RS1_U_MID), 64'(e_m1));
    check_eq("rs2_mid", 64'(RS2_U_MID), 64'(e_m2));
    check_eq("op_out", 64'(OP_OUT), 64'(op));
    check_eq("tag_out", 64'(TAG_OUT), 64'(tg));
    check_eq("ready_busy", 64'(REQ_READY), 64'd0);
    for (int i = 0; i < stall; i++) begin
      REQ_VALID = 1'b1; REQ_RS1 = $urandom; REQ_RS2 = $urandom; REQ_TAG = TAG_W'($urandom);
      tick();
      check_eq("stall_en", 64'({EN, RDY_M}), 64'd3);
      check_eq("stall_sum", SUM, e_sum);
      check_eq("stall_meta", 64'({SIGN, RS1_U_MID, RS2_U_MID, OP_OUT, TAG_OUT}),
               64'({e_sg, e_m1, e_m2, op, tg}));
      check_eq("stall_ready", 64'(REQ_READY), 64'd0);
    end
    REQ_VALID = 1'b0;
    if (kill) FLUSH = 1'b1;
    else      DN_READY = 1'b1;
    tick();
    FLUSH = 1'b0; DN_READY = 1'b0;
    check_eq("en_drop", 64'({EN, RDY_M}), 64'd0);
    check_eq("ready_back", 64'(REQ_READY), 64'd1);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'h0;
      1:       v = 32'h8000_0000;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'($urandom_range(0, 4095));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    logic seen_en;
    RST = 1'b1; REQ_VALID = 1'b0; REQ_OP = 2'b00; REQ_RS1 = '0; REQ_RS2 = '0;
    REQ_TAG = '0; FLUSH = 1'b0; DN_READY = 1'b0;
    tick();
    tick();
    check_eq("rst_en", 64'({EN, RDY_M, SIGN}), 64'd0);
    check_eq("rst_ready", 64'(REQ_READY), 64'd1);
    check_eq("rst_data", SUM | 64'(RS1_U_MID) | 64'(RS2_U_MID) | 64'(OP_OUT) | 64'(TAG_OUT), 64'd0);
    RST = 1'b0;
    tick();

    // Directed cases.
    run_req(2'b00, 32'd3, 32'd5, 5'd1, 0, 1'b0);
    run_req(2'b11, 32'h0000_0800, 32'd3, 5'd2, 0, 1'b0);
    run_req(2'b10, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 5'd3, 0, 1'b0);
    run_req(2'b01, 32'h8000_0000, 32'h8000_0000, 5'd4, 0, 1'b0);
    run_req(2'b01, 32'h0, 32'hFFFF_FFF0, 5'd5, 1, 1'b0);
    run_req(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 5'd6, 5, 1'b0);
    run_req(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 2, 1'b1);

    // FLUSH in ACC cycle 4 together with REQ_VALID.
    REQ_VALID = 1'b1; REQ_OP = 2'b01; REQ_RS1 = 32'h0001_2345; REQ_RS2 = 32'h0006_789A; REQ_TAG = 5'd9;
    tick();
    REQ_VALID = 1'b0;
    repeat (3) tick();
    FLUSH = 1'b1; REQ_VALID = 1'b1;
    tick();
    FLUSH = 1'b0; REQ_VALID = 1'b0;
    check_eq("flush_acc_en", 64'(EN), 64'd0);
    check_eq("flush_acc_ready", 64'(REQ_READY), 64'd1);
    seen_en = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (EN) seen_en = 1'b1;
    end
    check_eq("flush_acc_no_en", 64'(seen_en), 64'd0);

    // FLUSH in IDLE blocks a simultaneous request.
    FLUSH = 1'b1; REQ_VALID = 1'b1; REQ_RS1 = 32'd7; REQ_RS2 = 32'd7;
    tick();
    FLUSH = 1'b0; REQ_VALID = 1'b0;
    check_eq("flush_idle_ready", 64'(REQ_READY), 64'd1);
    seen_en = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (EN) seen_en = 1'b1;
    end
    check_eq("flush_idle_no_en", 64'(seen_en), 64'd0);
    run_req(2'b01, 32'h0001_2345, 32'h0006_789A, 5'd10, 0, 1'b0);

    // Reset in the middle of an operation.
    REQ_VALID = 1'b1; REQ_OP = 2'b10; REQ_RS1 = 32'hF000_0001; REQ_RS2 = 32'h0000_1234; REQ_TAG = 5'd17;
    tick();
    REQ_VALID = 1'b0;
    repeat (3) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check_eq("mrst_en", 64'({EN, RDY_M, SIGN}), 64'd0);
    check_eq("mrst_ready", 64'(REQ_READY), 64'd1);
    check_eq("mrst_data", SUM | 64'(RS1_U_MID) | 64'(RS2_U_MID) | 64'(OP_OUT) | 64'(TAG_OUT), 64'd0);
    seen_en = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (EN) seen_en = 1'b1;
    end
    check_eq("mrst_no_en", 64'(seen_en), 64'd0);

    // Randomized requests.
    for (int n = 0; n < 40; n++) begin
      run_req(2'($urandom), pick_operand(), pick_operand(), TAG_W'($urandom),
              int'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
